keyboard_decoder: RTL and testbench

KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

---
 rtl/keyboard_decoder_if.sv | 24 ++
 rtl/keyboard_decoder.sv | 191 +++++++++++++++++++
 tb/tb_keyboard_decoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/keyboard_decoder_if.sv
// Keyboard-side signal bundle: raw PS/2 lines in, decoded key outputs back.
interface keyboard_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key;
  logic       key_strobe;
  logic       frame_error;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  key,
    input  key_strobe,
    input  frame_error
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output key,
    output key_strobe,
    output frame_error
  );
endinterface

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the bus, frames 11-bit
// packets, and decodes make/break scancodes into a held-key ASCII value.
module keyboard_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 6500,
  parameter int unsigned FILTER_LEN     = 4
) (
  input logic               clk,
  input logic               rst,
  keyboard_decoder_if.slave kbd
);

  localparam int unsigned FltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic            clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic            flt_q, flt_d;
  logic [FltW-1:0] flt_cnt_q, flt_cnt_d;
  logic            fall;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_ok_q, par_ok_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            timeout, byte_vld;

  logic            ext_q, ext_d, brk_q, brk_d;
  logic [7:0]      key_q, key_d;
  logic            strobe_q, strobe_d;
  logic            frame_err_q, frame_err_d;
  logic            map_hit;
  logic [7:0]      map_ascii;

  // A level change is accepted only after FILTER_LEN agreeing samples.
  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    fall      = 1'b0;
    if (clk_s2_q != flt_q) begin
      if (flt_cnt_q == FltW'(FILTER_LEN - 1)) begin
        flt_d = clk_s2_q;
        fall  = flt_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    to_cnt_d    = to_cnt_q;
    frame_err_d = 1'b0;
    byte_vld    = 1'b0;
    timeout     = 1'b0;

    if (fall) begin
      to_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!data_s2_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        StData: begin
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_ok_d = (^shift_q) ^ data_s2_q;
          state_d  = StStop;
        end
        StStop: begin
          if (data_s2_q && par_ok_q) byte_vld    = 1'b1;
          else                       frame_err_d = 1'b1;
          state_d = StIdle;
        end
      endcase
    end else if (state_q == StIdle) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
      timeout     = 1'b1;
      state_d     = StIdle;
      to_cnt_d    = '0;
      frame_err_d = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_comb begin
    map_hit   = 1'b1;
    map_ascii = 8'h00;
    case ({ext_q, shift_q})
      9'h076:  map_ascii = 8'h1B;
      9'h05A:  map_ascii = 8'h0D;
      9'h016:  map_ascii = 8'h31;
      9'h01E:  map_ascii = 8'h32;
      9'h026:  map_ascii = 8'h33;
      9'h01D:  map_ascii = 8'h77;
      9'h01C:  map_ascii = 8'h61;
      9'h01B:  map_ascii = 8'h73;
      9'h023:  map_ascii = 8'h64;
      9'h175:  map_ascii = 8'h77;
      9'h16B:  map_ascii = 8'h61;
      9'h172:  map_ascii = 8'h73;
      9'h174:  map_ascii = 8'h64;
      default: map_hit   = 1'b0;
    endcase
  end

  // Break only clears the key it names, so a newer held key survives.
  always_comb begin
    key_d    = key_q;
    strobe_d = 1'b0;
    ext_d    = ext_q;
    brk_d    = brk_q;
    if (timeout) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (map_hit) begin
          if (!brk_q) begin
            key_d    = map_ascii;
            strobe_d = 1'b1;
          end else if (map_ascii == key_q) begin
            key_d = 8'h00;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      data_s1_q   <= 1'b1;
      data_s2_q   <= 1'b1;
      flt_q       <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_q       <= 8'h00;
      strobe_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= kbd.ps2_clk;
      clk_s2_q    <= clk_s1_q;
      data_s1_q   <= kbd.ps2_data;
      data_s2_q   <= data_s1_q;
      flt_q       <= flt_d;
      flt_cnt_q   <= flt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_q       <= key_d;
      strobe_q    <= strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign kbd.key         = key_q;
  assign kbd.key_strobe  = strobe_q;
  assign kbd.frame_error = frame_err_q;

endmodule

// File: tb/tb_keyboard_decoder.sv
// Scoreboarded bench: stimulus pushes expected strobe/error events, a monitor
// pops them whenever the decoder pulses an output.
module tb_keyboard_decoder;

  localparam int unsigned Timeout = 200;
  localparam int unsigned Half    = 20;

  typedef struct packed {
    logic       is_err;
    logic [7:0] key;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];

  keyboard_decoder_if kbd_if ();

  keyboard_decoder #(
    .TIMEOUT_CYCLES(Timeout),
    .FILTER_LEN    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kbd(kbd_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (kbd_if.key_strobe || kbd_if.frame_error)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: strobe=%b err=%b key=%h, none expected",
                 kbd_if.key_strobe, kbd_if.frame_error, kbd_if.key);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          check("err_event", {6'd0, kbd_if.frame_error, kbd_if.key_strobe}, 8'h02);
        end else begin
          check("strobe_flags", {6'd0, kbd_if.frame_error, kbd_if.key_strobe}, 8'h01);
          check("strobe_key", kbd_if.key, e.key);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    kbd_if.ps2_data = b;
    wait_cyc(Half);
    kbd_if.ps2_clk = 1'b0;
    wait_cyc(Half);
    kbd_if.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    kbd_if.ps2_data = 1'b1;
    wait_cyc(30);
  endtask

  task automatic expect_key(input logic [7:0] k);
    exp_q.push_back('{is_err: 1'b0, key: k});
  endtask

  task automatic expect_err();
    exp_q.push_back('{is_err: 1'b1, key: 8'h00});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bench not finished");
    $fatal(1, "watchdog");
  end

  initial begin
    kbd_if.ps2_clk  = 1'b1;
    kbd_if.ps2_data = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);
    check("reset_key", kbd_if.key, 8'h00);
    check("reset_strobe", {7'd0, kbd_if.key_strobe}, 8'h00);
    check("reset_err", {7'd0, kbd_if.frame_error}, 8'h00);

    expect_key(8'h1B);
    send_frame(8'h76, 0, 0);
    check("make_76", kbd_if.key, 8'h1B);

    expect_key(8'h77);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    check("ext_break_75", kbd_if.key, 8'h00);

    expect_key(8'h31);
    send_frame(8'h16, 0, 0);
    expect_key(8'h32);
    send_frame(8'h1E, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h16, 0, 0);
    check("old_break_keeps", kbd_if.key, 8'h32);

    expect_err();
    send_frame(8'h5A, 1, 0);
    check("bad_parity_key", kbd_if.key, 8'h32);
    expect_key(8'h0D);
    send_frame(8'h5A, 0, 0);

    // Partial frame: start bit plus four data bits, then silence.
    expect_err();
    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    kbd_if.ps2_data = 1'b1;
    wait_cyc(Timeout + 10);
    check("timeout_key", kbd_if.key, 8'h0D);
    expect_key(8'h33);
    send_frame(8'h26, 0, 0);

    send_frame(8'h15, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h16, 0, 0);
    check("unmapped_key", kbd_if.key, 8'h33);

    expect_err();
    send_frame(8'h1E, 0, 1);
    check("bad_stop_key", kbd_if.key, 8'h33);

    kbd_if.ps2_clk = 1'b0;
    wait_cyc(2);
    kbd_if.ps2_clk = 1'b1;
    wait_cyc(20);
    check("glitch_key", kbd_if.key, 8'h33);

    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rst = 1'b1;
    wait_cyc(3);
    kbd_if.ps2_data = 1'b1;
    kbd_if.ps2_clk  = 1'b1;
    rst = 1'b0;
    wait_cyc(10);
    check("midframe_reset_key", kbd_if.key, 8'h00);

    expect_key(8'h1B);
    send_frame(8'h76, 0, 0);
    expect_key(8'h1B);
    send_frame(8'h76, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h76, 0, 0);
    check("final_break", kbd_if.key, 8'h00);

    wait_cyc(20);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
